// File: rtl/nor_flash_ctrl_pkg.sv
// nor_flash_ctrl_pkg: op encoding, sequencer states and constants shared by the NOR flash controller
package nor_flash_ctrl_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_SECTOR_W = 4;
  localparam logic [DEF_DATA_W-1:0] ERASE_VAL = '1;
  typedef enum logic [1:0] {OP_READ, OP_PROGRAM, OP_ERASE, OP_RSVD} op_t;
  typedef enum logic [3:0] {
    IDLE, RD_REQ, RD_WAIT, PG_RD, PG_WAIT, PG_WR, PG_VRD, PG_VWAIT, ER_WR, DONE
  } state_t;
endpackage

// File: rtl/nor_flash_ctrl_if.sv
// nor_flash_ctrl_if: command/response handshake and raw array port of the NOR flash controller
interface nor_flash_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic rsp_err;
  logic busy;
  logic mem_we;
  logic mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, mem_rdata,
    input cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, mem_we, mem_re, mem_addr, mem_wdata
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_addr, cmd_wdata, mem_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, mem_we, mem_re, mem_addr, mem_wdata
  );
endinterface

// File: rtl/nor_flash_ctrl.sv
// nor_flash_ctrl: NOR flash command sequencer (READ/PROGRAM/ERASE_SECTOR); NOR_FLASH_CTRL_VERIFY_EN adds program readback verify
module nor_flash_ctrl
  import nor_flash_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SECTOR_W = DEF_SECTOR_W
) (
  input logic clk,
  input logic rst,
  nor_flash_ctrl_if.slave bus
);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  logic err, ready_en, accept;
  logic [SECTOR_W-1:0] cnt;
  assign accept = bus.cmd_valid & bus.cmd_ready;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // command latch, read capture, program result/error and erase word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en <= 1'b0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      err <= 1'b0;
      cnt <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        addr <= bus.cmd_addr;
        wdata <= bus.cmd_wdata;
        rdata <= '0;
        err <= bus.cmd_op == OP_RSVD;
        cnt <= '0;
      end
      if (state == RD_WAIT) rdata <= bus.mem_rdata;
      if (state == PG_WAIT) begin
        rdata <= bus.mem_rdata & wdata;
        err <= |(wdata & ~bus.mem_rdata);
      end
      if (state == PG_VWAIT) err <= err | (bus.mem_rdata != rdata);
      if (state == ER_WR) cnt <= cnt + 1'b1;
    end
  end
  // next-state sequencing
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = bus.cmd_op == OP_READ ? RD_REQ :
                                    bus.cmd_op == OP_PROGRAM ? PG_RD :
                                    bus.cmd_op == OP_ERASE ? ER_WR : DONE;
      RD_REQ: state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = DONE;
      PG_RD: state_nxt = PG_WAIT;
      PG_WAIT: state_nxt = PG_WR;
`ifdef NOR_FLASH_CTRL_VERIFY_EN
      PG_WR: state_nxt = PG_VRD;
`else
      PG_WR: state_nxt = DONE;
`endif
      PG_VRD: state_nxt = PG_VWAIT;
      PG_VWAIT: state_nxt = DONE;
      ER_WR: state_nxt = &cnt ? DONE : ER_WR;
      default: state_nxt = IDLE;
    endcase
  end
  // array port and handshake outputs; address/data forced to 0 whenever the array is not accessed
  always_comb begin
    bus.mem_re = state inside {RD_REQ, PG_RD, PG_VRD};
    bus.mem_we = state inside {PG_WR, ER_WR};
    bus.mem_addr = state == ER_WR ? {addr[ADDR_W-1:SECTOR_W], cnt} :
                   (bus.mem_re | bus.mem_we) ? addr : '0;
    bus.mem_wdata = state == ER_WR ? DATA_W'(ERASE_VAL) : state == PG_WR ? rdata : '0;
    bus.cmd_ready = ready_en & (state == IDLE);
    bus.busy = state != IDLE;
    bus.rsp_valid = state == DONE;
    bus.rsp_rdata = state == DONE ? rdata : '0;
    bus.rsp_err = (state == DONE) & err;
  end
endmodule
